// File: rtl/wr_spll_dac_arbiter.sv
// -----------------------------------------------------------------------------
// wr_spll_dac_arbiter
// Shares one serial DAC between the DMTD and output oscillator loops. Each
// channel owns a holding register and a pending flag. A round-robin arbiter
// picks the channel for the next 24-bit write-and-update frame.
//
// Parameters
//   CLK_DIV  SCLK half-period in clk_sys cycles (1..255)
//   CS_GAP   clk_sys cycles cs_n is held high after each frame (1..255)
//
// Ports
//   clk_sys, rst          clock (rising edge) and async active-high reset
//   dac_dmtd_data_i/load  DMTD DAC value and its one-cycle strobe
//   dac_out_data_i/load   output DAC value and its one-cycle strobe
//   dac_sclk_o            serial clock, idles low
//   dac_sdata_o           serial data, MSB first, changes on sclk falling edges
//   dac_cs_n_o            chip select, active-low
//   busy_o                high whenever the FSM is outside IDLE
//   dmtd_done_o/out_done_o one-cycle pulse in the first GAP cycle
//
// Optional feature (macro WR_SPLL_DAC_ARB_STATS_EN)
//   ovr_clr_i, ovr_dmtd_o[7:0], ovr_out_o[7:0]: saturating overrun counters
// -----------------------------------------------------------------------------
module wr_spll_dac_arbiter #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] dac_dmtd_data_i,
  input  logic        dac_dmtd_load_i,
  input  logic [15:0] dac_out_data_i,
  input  logic        dac_out_load_i,
  output logic        dac_sclk_o,
  output logic        dac_sdata_o,
  output logic        dac_cs_n_o,
  output logic        busy_o,
  output logic        dmtd_done_o,
  output logic        out_done_o
`ifdef WR_SPLL_DAC_ARB_STATS_EN
  ,
  input  logic        ovr_clr_i,
  output logic [7:0]  ovr_dmtd_o,
  output logic [7:0]  ovr_out_o
`endif
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned FRAME_W = 24;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [3:0]       CMD_WRITE_UPDATE = 4'b0011;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // channel encoding: 0 = DMTD, 1 = output
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic               busy_q;
  logic               dmtd_done_q, dmtd_done_d;
  logic               out_done_q, out_done_d;
  logic               cur_ch_q, cur_ch_d;
  logic               last_grant_q, last_grant_d;
  logic               pend_dmtd_q, pend_dmtd_d;
  logic               pend_out_q, pend_out_d;
  logic [15:0]        hold_dmtd_q, hold_dmtd_d;
  logic [15:0]        hold_out_q, hold_out_d;

  logic               grant_valid_c;
  logic               grant_ch_c;

  // round-robin grant: on a tie the channel not served last wins
  always_comb begin
    grant_valid_c = (state_q == ST_IDLE) && (pend_dmtd_q || pend_out_q);
    grant_ch_c    = (pend_dmtd_q && pend_out_q) ? ~last_grant_q : pend_out_q;
  end

  // holding registers; a load in the grant cycle re-arms pending
  always_comb begin
    pend_dmtd_d = pend_dmtd_q;
    pend_out_d  = pend_out_q;
    hold_dmtd_d = hold_dmtd_q;
    hold_out_d  = hold_out_q;
    if (grant_valid_c && !grant_ch_c) pend_dmtd_d = 1'b0;
    if (grant_valid_c &&  grant_ch_c) pend_out_d  = 1'b0;
    if (dac_dmtd_load_i) begin
      pend_dmtd_d = 1'b1;
      hold_dmtd_d = dac_dmtd_data_i;
    end
    if (dac_out_load_i) begin
      pend_out_d = 1'b1;
      hold_out_d = dac_out_data_i;
    end
  end

  // frame sequencer: outputs are computed for the next state and registered
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    cur_ch_d     = cur_ch_q;
    last_grant_d = last_grant_q;
    dmtd_done_d  = 1'b0;
    out_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_c) begin
          state_d      = ST_SETUP;
          cnt_d        = DIV_LAST;
          bit_d        = BIT_W'(FRAME_W - 1);
          shreg_d      = {CMD_WRITE_UPDATE, 3'b000, grant_ch_c,
                          grant_ch_c ? hold_out_q : hold_dmtd_q};
          cur_ch_d     = grant_ch_c;
          last_grant_d = grant_ch_c;
          cs_n_d       = 1'b0;
          sclk_d       = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          cnt_d   = DIV_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d = DIV_LAST;
          if (sclk_q) begin
            // falling edge: present the next bit; bit 0 low phase is HOLD
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            if (bit_q == '0) state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d     = ST_GAP;
          cs_n_d      = 1'b1;
          cnt_d       = GAP_LAST;
          dmtd_done_d = ~cur_ch_q;
          out_done_d  = cur_ch_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      dmtd_done_q  <= 1'b0;
      out_done_q   <= 1'b0;
      cur_ch_q     <= 1'b0;
      last_grant_q <= 1'b1;
      pend_dmtd_q  <= 1'b0;
      pend_out_q   <= 1'b0;
      hold_dmtd_q  <= '0;
      hold_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= (state_d != ST_IDLE);
      dmtd_done_q  <= dmtd_done_d;
      out_done_q   <= out_done_d;
      cur_ch_q     <= cur_ch_d;
      last_grant_q <= last_grant_d;
      pend_dmtd_q  <= pend_dmtd_d;
      pend_out_q   <= pend_out_d;
      hold_dmtd_q  <= hold_dmtd_d;
      hold_out_q   <= hold_out_d;
    end
  end

  assign dac_sclk_o  = sclk_q;
  assign dac_sdata_o = shreg_q[FRAME_W-1];
  assign dac_cs_n_o  = cs_n_q;
  assign busy_o      = busy_q;
  assign dmtd_done_o = dmtd_done_q;
  assign out_done_o  = out_done_q;

`ifdef WR_SPLL_DAC_ARB_STATS_EN
  logic       ovr_dmtd_c;
  logic       ovr_out_c;
  logic [7:0] ovr_dmtd_q;
  logic [7:0] ovr_out_q;

  // a load while pending is an overrun, unless the flag is being consumed
  always_comb begin
    ovr_dmtd_c = dac_dmtd_load_i && pend_dmtd_q && !(grant_valid_c && !grant_ch_c);
    ovr_out_c  = dac_out_load_i  && pend_out_q  && !(grant_valid_c &&  grant_ch_c);
  end

  // saturating counters, clear has priority
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ovr_dmtd_q <= '0;
      ovr_out_q  <= '0;
    end else if (ovr_clr_i) begin
      ovr_dmtd_q <= '0;
      ovr_out_q  <= '0;
    end else begin
      if (ovr_dmtd_c && (ovr_dmtd_q != 8'hFF)) ovr_dmtd_q <= ovr_dmtd_q + 8'd1;
      if (ovr_out_c  && (ovr_out_q  != 8'hFF)) ovr_out_q  <= ovr_out_q  + 8'd1;
    end
  end

  assign ovr_dmtd_o = ovr_dmtd_q;
  assign ovr_out_o  = ovr_out_q;
`endif

endmodule

// File: tb/tb_wr_spll_dac_arbiter.sv
// Testbench for wr_spll_dac_arbiter: table of single-strobe transactions plus
// hand sequences for latency, overrun, mid-frame reset and alternation.
module tb_wr_spll_dac_arbiter;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 2;
  localparam int LOW_LEN = 49 * CLK_DIV;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [15:0] dac_dmtd_data_i;
  logic        dac_dmtd_load_i;
  logic [15:0] dac_out_data_i;
  logic        dac_out_load_i;
  logic        dac_sclk_o;
  logic        dac_sdata_o;
  logic        dac_cs_n_o;
  logic        busy_o;
  logic        dmtd_done_o;
  logic        out_done_o;
`ifdef WR_SPLL_DAC_ARB_STATS_EN
  logic        ovr_clr_i;
  logic [7:0]  ovr_dmtd_o;
  logic [7:0]  ovr_out_o;
`endif

  wr_spll_dac_arbiter #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk_sys         (clk_sys),
    .rst             (rst),
    .dac_dmtd_data_i (dac_dmtd_data_i),
    .dac_dmtd_load_i (dac_dmtd_load_i),
    .dac_out_data_i  (dac_out_data_i),
    .dac_out_load_i  (dac_out_load_i),
    .dac_sclk_o      (dac_sclk_o),
    .dac_sdata_o     (dac_sdata_o),
    .dac_cs_n_o      (dac_cs_n_o),
    .busy_o          (busy_o),
    .dmtd_done_o     (dmtd_done_o),
    .out_done_o      (out_done_o)
`ifdef WR_SPLL_DAC_ARB_STATS_EN
    ,
    .ovr_clr_i       (ovr_clr_i),
    .ovr_dmtd_o      (ovr_dmtd_o),
    .ovr_out_o       (ovr_out_o)
`endif
  );

  always #4 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // serial-bus monitor: captures frames as a DAC would, on sclk rising edges
  logic [23:0] fr_word[$];
  int          fr_bits[$];
  int          fr_low[$];
  int          n_dd = 0, n_od = 0, done_bad = 0, sdata_bad = 0;
  int          cur_bits = 0, cur_low = 0;
  logic [23:0] cur_word = '0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0, sdata_prev = 1'b0;

  always @(negedge clk_sys) begin
    if (rst) begin
      cur_bits = 0;
      cur_low  = 0;
      cur_word = '0;
    end else begin
      if (!dac_cs_n_o) cur_low++;
      if (!dac_cs_n_o && !cs_prev && (dac_sdata_o !== sdata_prev) && !(sclk_prev && !dac_sclk_o))
        sdata_bad++;
      if (dac_sclk_o && !sclk_prev) begin
        cur_word = {cur_word[22:0], dac_sdata_o};
        cur_bits++;
      end
      if (dac_cs_n_o && !cs_prev) begin
        fr_word.push_back(cur_word);
        fr_bits.push_back(cur_bits);
        fr_low.push_back(cur_low);
        cur_bits = 0;
        cur_low  = 0;
      end
      if (dmtd_done_o) begin
        n_dd++;
        if (!(dac_cs_n_o && !cs_prev)) done_bad++;
      end
      if (out_done_o) begin
        n_od++;
        if (!(dac_cs_n_o && !cs_prev)) done_bad++;
      end
    end
    cs_prev    = dac_cs_n_o;
    sclk_prev  = dac_sclk_o;
    sdata_prev = dac_sdata_o;
  end

  task automatic clear_mon();
    @(posedge clk_sys);
    fr_word.delete();
    fr_bits.delete();
    fr_low.delete();
    n_dd = 0;
    n_od = 0;
  endtask

  task automatic strobe(input logic ld_d, input logic [15:0] dd, input logic ld_o, input logic [15:0] od);
    @(negedge clk_sys);
    dac_dmtd_load_i = ld_d;
    dac_dmtd_data_i = dd;
    dac_out_load_i  = ld_o;
    dac_out_data_i  = od;
    @(negedge clk_sys);
    dac_dmtd_load_i = 1'b0;
    dac_out_load_i  = 1'b0;
  endtask

  task automatic wait_quiet();
    int idle_run = 0;
    int n = 0;
    while (idle_run < 8 && n < 3000) begin
      @(negedge clk_sys);
      n++;
      if (busy_o) idle_run = 0;
      else        idle_run++;
    end
    check("quiet_timeout", 32'(idle_run >= 8), 32'd1);
  endtask

`ifdef WR_SPLL_DAC_ARB_STATS_EN
  task automatic pulse_clr();
    @(negedge clk_sys);
    ovr_clr_i = 1'b1;
    @(negedge clk_sys);
    ovr_clr_i = 1'b0;
  endtask
`endif

  typedef struct {
    logic        ld_d;
    logic [15:0] dd;
    logic        ld_o;
    logic [15:0] od;
    int          nfr;
    logic [23:0] w0;
    logic [23:0] w1;
    int          exp_dd;
    int          exp_od;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // after reset last-grant is the output channel, so the first tie goes to DMTD
    vecs[0] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 2, 24'h301111, 24'h312222, 1, 1};
    vecs[1] = '{1'b1, 16'hA5C3, 1'b0, 16'h0000, 1, 24'h30A5C3, 24'h000000, 1, 0};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1, 24'h310000, 24'h000000, 0, 1};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'hFFFF, 1, 24'h31FFFF, 24'h000000, 0, 1};
    vecs[4] = '{1'b1, 16'h0001, 1'b1, 16'h8000, 2, 24'h300001, 24'h318000, 1, 1};
    vecs[5] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1, 24'h30FFFF, 24'h000000, 1, 0};
    vecs[6] = '{1'b1, 16'hABCD, 1'b1, 16'h1234, 2, 24'h311234, 24'h30ABCD, 1, 1};

    rst = 1'b1;
    dac_dmtd_data_i = '0;
    dac_dmtd_load_i = 1'b0;
    dac_out_data_i  = '0;
    dac_out_load_i  = 1'b0;
`ifdef WR_SPLL_DAC_ARB_STATS_EN
    ovr_clr_i = 1'b0;
`endif
    repeat (3) @(negedge clk_sys);
    check("rst_sclk",  32'(dac_sclk_o),  32'd0);
    check("rst_sdata", 32'(dac_sdata_o), 32'd0);
    check("rst_cs_n",  32'(dac_cs_n_o),  32'd1);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_done",  32'({dmtd_done_o, out_done_o}), 32'd0);
`ifdef WR_SPLL_DAC_ARB_STATS_EN
    check("rst_ovr", 32'({ovr_dmtd_o, ovr_out_o}), 32'd0);
`endif
    rst = 1'b0;

    // table-driven single-strobe transactions
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      strobe(vecs[i].ld_d, vecs[i].dd, vecs[i].ld_o, vecs[i].od);
      wait_quiet();
      check($sformatf("v%0d_nframes", i), 32'(fr_word.size()), 32'(vecs[i].nfr));
      check($sformatf("v%0d_word0", i), 32'(fr_word[0]), 32'(vecs[i].w0));
      check($sformatf("v%0d_bits0", i), 32'(fr_bits[0]), 32'd24);
      check($sformatf("v%0d_low0", i),  32'(fr_low[0]),  32'(LOW_LEN));
      if (vecs[i].nfr > 1) begin
        check($sformatf("v%0d_word1", i), 32'(fr_word[1]), 32'(vecs[i].w1));
        check($sformatf("v%0d_low1", i),  32'(fr_low[1]),  32'(LOW_LEN));
      end
      check($sformatf("v%0d_dmtd_done", i), 32'(n_dd), 32'(vecs[i].exp_dd));
      check($sformatf("v%0d_out_done", i),  32'(n_od), 32'(vecs[i].exp_od));
    end

    // load-to-cs_n latency of two cycles
    clear_mon();
    @(negedge clk_sys);
    dac_dmtd_load_i = 1'b1;
    dac_dmtd_data_i = 16'h5A5A;
    @(negedge clk_sys);
    dac_dmtd_load_i = 1'b0;
    check("lat_cycle1_cs_n", 32'(dac_cs_n_o), 32'd1);
    check("lat_cycle1_busy", 32'(busy_o),     32'd0);
    @(negedge clk_sys);
    check("lat_cycle2_cs_n", 32'(dac_cs_n_o), 32'd0);
    check("lat_cycle2_busy", 32'(busy_o),     32'd1);
    wait_quiet();
    check("lat_word", 32'(fr_word[0]), 32'h305A5A);

    // loads during a frame only update the holding register
`ifdef WR_SPLL_DAC_ARB_STATS_EN
    pulse_clr();
`endif
    clear_mon();
    strobe(1'b0, 16'h0000, 1'b1, 16'h0BEE);
    repeat (5) @(negedge clk_sys);
    for (int k = 1; k <= 3; k++) begin
      dac_dmtd_load_i = 1'b1;
      dac_dmtd_data_i = 16'(k);
      @(negedge clk_sys);
    end
    dac_dmtd_load_i = 1'b0;
    wait_quiet();
    check("ovr_nframes", 32'(fr_word.size()), 32'd2);
    check("ovr_word0",   32'(fr_word[0]), 32'h310BEE);
    check("ovr_word1",   32'(fr_word[1]), 32'h300003);
`ifdef WR_SPLL_DAC_ARB_STATS_EN
    check("ovr_dmtd_cnt", 32'(ovr_dmtd_o), 32'd2);
    check("ovr_out_cnt",  32'(ovr_out_o),  32'd0);
`endif

    // reset at bit 10 aborts the frame and drops the pending value
    clear_mon();
    strobe(1'b0, 16'h0000, 1'b1, 16'h1357);
    repeat (10) @(negedge clk_sys);
    dac_out_load_i = 1'b1;
    dac_out_data_i = 16'h2468;
    @(negedge clk_sys);
    dac_out_load_i = 1'b0;
    begin
      int n = 0;
      while (cur_bits < 14 && n < 1000) begin
        @(posedge clk_sys);
        n++;
      end
      check("abort_reach_bit10", 32'(cur_bits), 32'd14);
    end
    #1;
    check("abort_sclk_before", 32'(dac_sclk_o), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_cs_n",  32'(dac_cs_n_o),  32'd1);
    check("abort_sclk",  32'(dac_sclk_o),  32'd0);
    check("abort_sdata", 32'(dac_sdata_o), 32'd0);
    check("abort_busy",  32'(busy_o),      32'd0);
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    repeat (400) @(negedge clk_sys);
    check("abort_nframes", 32'(fr_word.size()), 32'd0);
    check("abort_done",    32'(n_dd + n_od),    32'd0);
    check("abort_idle",    32'(busy_o),         32'd0);

`ifdef WR_SPLL_DAC_ARB_STATS_EN
    // saturation, clear, and clear beating a simultaneous increment
    strobe(1'b0, 16'h0000, 1'b1, 16'h0000);
    for (int k = 0; k < 400; k++) begin
      dac_dmtd_load_i = 1'b1;
      dac_dmtd_data_i = 16'(k);
      @(negedge clk_sys);
    end
    dac_dmtd_load_i = 1'b0;
    wait_quiet();
    check("sat_dmtd", 32'(ovr_dmtd_o), 32'hFF);
    pulse_clr();
    check("clr_dmtd", 32'(ovr_dmtd_o), 32'd0);
    strobe(1'b0, 16'h0000, 1'b1, 16'h0000);
    repeat (5) @(negedge clk_sys);
    dac_dmtd_load_i = 1'b1;
    @(negedge clk_sys);
    ovr_clr_i = 1'b1;
    @(negedge clk_sys);
    ovr_clr_i = 1'b0;
    check("clr_wins", 32'(ovr_dmtd_o), 32'd0);
    @(negedge clk_sys);
    dac_dmtd_load_i = 1'b0;
    check("inc_after_clr", 32'(ovr_dmtd_o), 32'd1);
    wait_quiet();
`endif

    // both channels kept pending: frames must alternate
    clear_mon();
    for (int r = 0; r < 16; r++) begin
      strobe(1'b1, 16'(16'h0100 + r), 1'b1, 16'(16'h0200 + r));
      repeat (98) @(negedge clk_sys);
    end
    wait_quiet();
    check("alt_enough_frames", 32'(fr_word.size() >= 6), 32'd1);
    for (int k = 1; k < fr_word.size(); k++)
      check($sformatf("alt_frame%0d", k), 32'(fr_word[k][16] != fr_word[k-1][16]), 32'd1);
    check("alt_done_total", 32'(n_dd + n_od), 32'(fr_word.size()));

    check("sdata_only_on_fall", 32'(sdata_bad), 32'd0);
    check("done_in_first_gap",  32'(done_bad),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wr_spll_dac_arbiter.md
WR_SPLL_DAC_ARBITER -- requirements
Module: wr_spll_dac_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk_sys cycles; legal range 1..255.
REQ-002 SHALL have parameter CS_GAP, default 2: clk_sys cycles cs_n held high between frames; legal range 1..255.
REQ-003 SHALL have port clk_sys  in  1  the single clock of the block, 125 MHz nominal, used on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port dac_dmtd_data_i  in  16  DMTD oscillator DAC value.
REQ-006 SHALL have port dac_dmtd_load_i  in  1  one-cycle strobe qualifying dac_dmtd_data_i.
REQ-007 SHALL have port dac_out_data_i  in  16  output oscillator DAC value.
REQ-008 SHALL have port dac_out_load_i  in  1  one-cycle strobe qualifying dac_out_data_i.
REQ-009 SHALL have port dac_sclk_o  out  1  serial clock; idles low.
REQ-010 SHALL have port dac_sdata_o  out  1  serial data, MSB first.
REQ-011 SHALL have port dac_cs_n_o  out  1  chip select, active-low.
REQ-012 SHALL have port busy_o  out  1  high whenever the FSM is outside IDLE.
REQ-013 SHALL have ports dmtd_done_o / out_done_o  out  1  one-cycle pulse when that channel's frame completes.

Function
REQ-014 SHALL keep one holding register and one pending flag per channel; a load strobe stores the data and sets pending on the next edge.
REQ-015 Load on a channel that is already pending SHALL overwrite the held data (newest wins) and count as an overrun.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-017 In IDLE with any channel pending, the arbiter SHALL grant one channel, copy its data into the shift register, clear its pending flag and enter SETUP in the same cycle.
REQ-018 Arbitration SHALL be round-robin: with both channels pending, the channel not granted last wins; with one pending, that channel wins.
REQ-019 A load on the channel being granted, in the grant cycle, SHALL re-set pending with the new data and SHALL NOT count as an overrun.
REQ-020 Frame SHALL be 24 bits: [23:20]=4'b0011 (write and update), [19:16]=4'h0 for DMTD or 4'h1 for output, [15:0]=data.
REQ-021 SETUP SHALL drive cs_n low, sclk low and sdata=bit 23 for CLK_DIV cycles.
REQ-022 SHIFT SHALL run 24 bits, each as sclk high for CLK_DIV cycles then sclk low for CLK_DIV cycles; sdata SHALL change only on sclk falling edges.
REQ-023 The low phase of bit 0 SHALL be HOLD; cs_n low time SHALL total 49*CLK_DIV cycles.
REQ-024 GAP SHALL drive cs_n high for CS_GAP cycles and then return to IDLE.
REQ-025 The granted channel's done pulse SHALL assert in the first GAP cycle.
REQ-026 Load-to-cs_n-low latency from IDLE SHALL be 2 clk_sys cycles.
REQ-027 Loads arriving during a frame SHALL only update holding registers and SHALL NOT affect the frame in progress.

Reset
REQ-028 Asserting rst SHALL immediately force dac_sclk_o=0, dac_sdata_o=0, dac_cs_n_o=1, busy_o=0 and both done pulses=0.
REQ-029 Asserting rst SHALL immediately clear both pending flags and enter IDLE.
REQ-030 Reset SHALL set last-grant to the output channel, so DMTD wins the first tie.
REQ-031 Reset mid-frame SHALL abort the frame with no done pulse; a held value is not retransmitted.

Configuration
REQ-032 With WR_SPLL_DAC_ARB_STATS_EN defined, the block SHALL add ports ovr_clr_i (in, 1), ovr_dmtd_o (out, 8) and ovr_out_o (out, 8).
REQ-033 With WR_SPLL_DAC_ARB_STATS_EN defined, ovr_dmtd_o and ovr_out_o SHALL be saturating overrun counters, reset to 0 and cleared by ovr_clr_i; clear wins over a simultaneous increment.
REQ-034 Without WR_SPLL_DAC_ARB_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-035 Single DMTD load 16'hA5C3, CLK_DIV=4 -> cs_n low 2 cycles later for 196 cycles; shifted word 24'h30A5C3; dmtd_done_o one pulse.
REQ-036 Both loads in the same cycle after reset (DMTD 16'h1111, out 16'h2222) -> frame 24'h301111, then after CS_GAP=2 frame 24'h312222.
REQ-037 Three DMTD loads (1,2,3) during an output frame -> next DMTD frame carries 16'h0003; ovr_dmtd_o=2 when stats enabled.
REQ-038 rst asserted at bit 10 of a frame -> cs_n=1 and sclk=0 immediately; no done pulse; no frame after release without a new load.
REQ-039 300 DMTD overruns with stats enabled -> ovr_dmtd_o saturates at 8'hFF; ovr_clr_i pulse -> 0.
REQ-040 Continuous alternating loads on both channels -> frames alternate DMTD/out; no channel is served twice in a row while the other is pending.
